// File: rtl/serial_output.sv
// 8N1 UART transmitter fed by a 32-bit stb/ack stream; only bits [7:0] of each
// accepted word go out on the line, LSB first, framed by a start and stop bit.
module serial_output #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_stb,
  output logic        in_ack,
  output logic        tx
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_end;

  // Upper word bits carry nothing for a byte-wide line.
  logic unused_upper;
  assign unused_upper = ^in[31:8];

  assign baud_end = (baud_cnt == BAUD_LAST);

  // The counter free-runs through every bit period of a frame and is parked at
  // zero while idle, so each period is exactly CLOCKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
    end else if (baud_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // NOTE: every register here, including the data shift register, is reset so
  // an interrupted frame leaves no residue; state uses non-blocking updates so
  // all branches see the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      in_ack  <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // First edge out of reset only raises ack; a transfer needs ack seen high.
          if (!in_ack) begin
            in_ack <= 1'b1;
          end else if (in_stb) begin
            shift  <= in[7:0];
            in_ack <= 1'b0;
            tx     <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (baud_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            in_ack <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_output.sv
// Randomized bench for serial_output: accepted words are queued with their
// transfer cycle, and a line monitor decodes each frame from tx and compares.
module tb_serial_output;

  localparam int CPB = 4;

  typedef struct {
    int         t;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic        in_stb;
  logic        in_ack;
  logic        tx;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  int   starts[$];

  serial_output #(
    .CLOCK_FREQUENCY(8),
    .BAUD_RATE      (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .in_stb(in_stb),
    .in_ack(in_ack),
    .tx    (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard feed: a transfer edge queues the byte the line must carry.
  always @(posedge clk) begin
    if (rst && in_stb && in_ack) sb.push_back('{t: cyc, data: in[7:0]});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive point: shortly after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_frame();
    exp_t       e;
    int         t0;
    logic [3:0] s;
    logic       lvl;
    logic       ack_low;
    t0 = cyc - 1;
    starts.push_back(t0);
    check("frame queued", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("start time", t0, e.t);
    ack_low = 1'b1;
    for (int b = 0; b < 10; b++) begin
      lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
      for (int j = 0; j < CPB; j++) begin
        if (b != 0 || j != 0) @(negedge clk);
        if (!rst) return;
        s[j] = tx;
        if (in_ack) ack_low = 1'b0;
      end
      check($sformatf("byte %02h line bit %0d", e.data, b), s, {CPB{lvl}});
    end
    @(negedge clk);
    if (!rst) return;
    check("ack low during frame", ack_low, 1);
    check("ack back after frame", in_ack, 1);
  endtask

  initial begin : monitor
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev_tx && !tx) check_frame();
      prev_tx = tx;
    end
  end

  task automatic do_reset(input int n);
    logic ok;
    rst = 1'b0;
    #1;
    ok = (tx === 1'b1) && (in_ack === 1'b0);
    for (int i = 0; i < n; i++) begin
      tick();
      if (!((tx === 1'b1) && (in_ack === 1'b0))) ok = 1'b0;
    end
    check("outputs held in reset", ok, 1);
    rst = 1'b1;
    tick();
    check("ack one edge after release", in_ack, 1);
  endtask

  task automatic send(input logic [31:0] word);
    logic a;
    bit   done;
    done   = 0;
    in     = word;
    in_stb = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      a = in_ack;
      tick();
      done = a;
    end
    check("word accepted", 32'(done), 1);
    in_stb = 1'b0;
    in     = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !in_ack; i++) tick();
    check("transmitter idle", in_ack, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int   n0;
    int   d;
    logic all_high;
    logic a;
    bit   done;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    in     = '0;
    in_stb = 1'b0;
    tick();

    do_reset(5);

    send(32'h0000_00A5);
    wait_idle();
    send(32'hFFFF_FF00);
    wait_idle();
    send(32'h0000_0000);
    wait_idle();

    // Back-to-back with strobe held; data changes once the first word is taken.
    in     = 32'h0000_0055;
    in_stb = 1'b1;
    done   = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      a = in_ack;
      tick();
      done = a;
    end
    in   = 32'h0000_000F;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      a = in_ack;
      tick();
      done = a;
    end
    check("second word accepted", 32'(done), 1);
    in_stb = 1'b0;
    in     = $urandom;
    wait_idle();
    n0 = starts.size();
    d  = (n0 >= 2) ? starts[n0-1] - starts[n0-2] : -1;
    check("back-to-back start spacing", d, 41);

    // Strobe raised and withdrawn while held in reset.
    rst    = 1'b0;
    in     = 32'h0000_00C3;
    in_stb = 1'b1;
    tick();
    tick();
    in_stb = 1'b0;
    tick();
    n0     = starts.size();
    rst    = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1) all_high = 1'b0;
    end
    check("withdrawn strobe line idle", all_high, 1);
    check("withdrawn strobe no frame", starts.size(), n0);

    // Reset during data bit 3 of a zero byte.
    send(32'h0000_0000);
    for (int i = 0; i < 17; i++) tick();
    rst = 1'b0;
    #1;
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset ack", in_ack, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("ack after mid-frame reset", in_ack, 1);
    send(32'h0000_0081);
    wait_idle();

    // Random bytes, random gaps, with a strobe pulse during some frames.
    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) tick();
      send($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        in_stb = 1'b1;
        tick();
        tick();
        in_stb = 1'b0;
      end
      wait_idle();
    end

    for (int i = 0; i < 5; i++) tick();
    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
